// File: rtl/srl_pkg.sv
// Shared helpers for SRL-based buffers: width math and occupancy flag decode.
package srl_pkg;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } srl_flags_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int cnt_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  localparam int CNT_W = cnt_width(16);

  function automatic srl_flags_t decode_flags(input int cnt, input int depth,
                                              input int af_thresh, input int ae_thresh);
    srl_flags_t f;
    f.empty        = (cnt == 0);
    f.full         = (cnt == depth);
    f.almost_empty = (cnt <= ae_thresh);
    f.almost_full  = (cnt >= af_thresh);
    return f;
  endfunction

endpackage

// File: rtl/srl_dyn_array.sv
// WIDTH x DEPTH addressable shift register: CE shifts D into stage 0, Q reads any stage.
module srl_dyn_array
  import srl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter logic [WIDTH*DEPTH-1:0] INIT = '0,
  parameter logic IS_CLK_INVERTED = 1'b0
) (
  input  logic                     clk,
  input  logic                     ce,
  input  logic [WIDTH-1:0]         d,
  input  logic [clog2(DEPTH)-1:0]  addr,
  output logic [WIDTH-1:0]         q
);

  // No reset on the storage, like the silicon primitive; contents power up to INIT.
  logic [DEPTH-1:0][WIDTH-1:0] mem = INIT;
  logic clk_int;

  assign clk_int = clk ^ IS_CLK_INVERTED;

  always_ff @(posedge clk_int) begin
    if (ce) mem <= {mem[DEPTH-2:0], d};
  end

  assign q = mem[addr];

endmodule

// File: rtl/srl_fifo.sv
// First-word-fall-through FIFO on an addressable shift register; read address tracks the oldest entry.
module srl_fifo
  import srl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter logic [WIDTH*DEPTH-1:0] INIT = '0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  parameter logic IS_CLK_INVERTED = 1'b0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      WR_EN,
  input  logic [WIDTH-1:0]          D,
  output logic                      FULL,
  output logic                      ALMOST_FULL,
  input  logic                      RD_EN,
  output logic [WIDTH-1:0]          Q,
  output logic                      EMPTY,
  output logic                      ALMOST_EMPTY,
  output logic [clog2(DEPTH):0]     COUNT,
  output logic                      OVERFLOW,
  output logic                      UNDERFLOW
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("srl_fifo: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH > DEPTH) begin : g_bad_af
    $error("srl_fifo: AF_THRESH exceeds DEPTH");
  end
  if (AE_THRESH >= DEPTH) begin : g_bad_ae
    $error("srl_fifo: AE_THRESH must be below DEPTH");
  end

  logic [CW-1:0] count;
  logic [AW-1:0] rd_addr;
  logic          wr_acc;
  logic          rd_acc;
  logic          clk_int;
  srl_flags_t    flags;

  assign clk_int = CLK ^ IS_CLK_INVERTED;
  assign flags   = decode_flags(int'(count), DEPTH, AF_THRESH, AE_THRESH);

  assign wr_acc = WR_EN & ~flags.full;
  assign rd_acc = RD_EN & ~flags.empty;

  always_ff @(posedge clk_int or posedge RST) begin
    if (RST) begin
      count     <= '0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      OVERFLOW  <= WR_EN & flags.full;
      UNDERFLOW <= RD_EN & flags.empty;
    end
  end

  // A concurrent shift moves the next-oldest entry onto address count-1, so no adjustment is needed.
  assign rd_addr = (count == '0) ? '0 : AW'(count - CW'(1));

  srl_dyn_array #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .INIT(INIT),
    .IS_CLK_INVERTED(IS_CLK_INVERTED)
  ) u_array (
    .clk(CLK),
    .ce(wr_acc),
    .d(D),
    .addr(rd_addr),
    .q(Q)
  );

  assign COUNT        = count;
  assign EMPTY        = flags.empty;
  assign FULL         = flags.full;
  assign ALMOST_EMPTY = flags.almost_empty;
  assign ALMOST_FULL  = flags.almost_full;

endmodule
